// File: rtl/mem_test_seq.sv
// rtl/mem_test_seq.sv - autonomous write/read-back memory exerciser
//
// Purpose: drives a go/done memory controller. It writes a generated pattern
// over a contiguous address window, then reads the window back and compares
// each word. It reports pass/fail, the error count, the first failing address
// and any controller timeout.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           one-cycle test request (ignored unless idle)
//   base_addr       window start address (latched on start)
//   seed, invert    pattern control (latched on start)
//   mem_addr, mem_wdata, mem_we, mem_go    request to the controller
//   mem_rdata, mem_done                    completion from the controller
//   busy            test in progress
//   pass, fail      result of the last test (held until next start)
//   timeout         controller failed to complete an access in time
//   err_count       saturating mismatch count
//   first_err_addr  address of the first mismatch of the test
//   last_rdata      most recently read word
module mem_test_seq #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 8,
  parameter int NUM_WORDS = 16,
  parameter int CNT_W     = 8,
  parameter int TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DATA_W-1:0] seed,
  input  logic              invert,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_we,
  output logic              mem_go,
  input  logic              mem_done,
  output logic              busy,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] last_rdata
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, W_ISSUE, W_GUARD, W_WAIT, R_ISSUE, R_GUARD, R_WAIT, FINISH
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] seed_q;
  logic              inv_q;
  logic [IDX_W-1:0]  idx;
  logic [TO_W-1:0]   to_cnt;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] pattern;
  logic              to_hit;
  logic              mismatch;
  logic              last_word;

  // Address and data come straight from the latched window state and idx, so
  // they stay stable for the whole issue/guard/wait sequence of an access.
  always_comb begin
    sum       = seed_q + DATA_W'(idx);
    pattern   = inv_q ? ~sum : sum;
    mem_addr  = base_q + ADDR_W'(idx);
    mem_wdata = pattern;
    mismatch  = (mem_rdata != pattern);
    last_word = (idx == LAST_IDX);
    // to_cnt counts completed wait cycles; hitting TIMEOUT-1 while still
    // waiting means this is the TIMEOUT-th cycle without completion.
    to_hit    = (to_cnt == TO_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // mem_go is decoded from the state register and gated by mem_done, so it
  // can never assert while the controller is busy and it drops the moment
  // reset forces the state back to IDLE.
  always_comb begin
    state_nx = state;
    mem_go   = 1'b0;
    mem_we   = 1'b0;
    busy     = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = W_ISSUE;
      end
      W_ISSUE: begin
        mem_we = 1'b1;
        if (mem_done) begin
          mem_go   = 1'b1;
          state_nx = W_GUARD;
        end
      end
      W_GUARD: begin
        mem_we   = 1'b1;
        state_nx = W_WAIT;
      end
      W_WAIT: begin
        mem_we = 1'b1;
        if (mem_done)    state_nx = last_word ? R_ISSUE : W_ISSUE;
        else if (to_hit) state_nx = IDLE;
      end
      R_ISSUE: begin
        if (mem_done) begin
          mem_go   = 1'b1;
          state_nx = R_GUARD;
        end
      end
      R_GUARD: state_nx = R_WAIT;
      R_WAIT: begin
        if (mem_done)    state_nx = last_word ? FINISH : R_ISSUE;
        else if (to_hit) state_nx = IDLE;
      end
      FINISH: begin
        busy     = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q         <= '0;
      seed_q         <= '0;
      inv_q          <= 1'b0;
      idx            <= '0;
      to_cnt         <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      last_rdata     <= '0;
      pass           <= 1'b0;
      fail           <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q         <= base_addr;
            seed_q         <= seed;
            inv_q          <= invert;
            idx            <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            timeout        <= 1'b0;
            pass           <= 1'b0;
            fail           <= 1'b0;
          end
        end
        W_GUARD, R_GUARD: to_cnt <= '0;
        W_WAIT, R_WAIT: begin
          if (mem_done) begin
            if (state == R_WAIT) begin
              last_rdata <= mem_rdata;
              if (mismatch) begin
                if (err_count != {CNT_W{1'b1}}) err_count <= err_count + 1'b1;
                // err_count is cleared at start, so zero marks the first miss.
                if (err_count == '0) first_err_addr <= mem_addr;
              end
            end
            idx <= last_word ? '0 : idx + 1'b1;
          end else if (to_hit) begin
            timeout <= 1'b1;
            fail    <= 1'b1;
            pass    <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        FINISH: begin
          pass <= (err_count == '0);
          fail <= (err_count != '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_test_seq.sv
// tb/tb_mem_test_seq.sv - scoreboard bench for mem_test_seq with a controller model
module tb_mem_test_seq;
  localparam int NW = 16;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [7:0]  seed = '0;
  logic        invert = 1'b0;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_we, mem_go, mem_done, busy, pass, fail, timeout;
  logic [7:0]  err_count;
  logic [31:0] first_err_addr;
  logic [7:0]  last_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_test_seq #(.ADDR_W(32), .DATA_W(8), .NUM_WORDS(NW), .CNT_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .seed(seed),
    .invert(invert), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_go(mem_go), .mem_done(mem_done), .busy(busy), .pass(pass),
    .fail(fail), .timeout(timeout), .err_count(err_count),
    .first_err_addr(first_err_addr), .last_rdata(last_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [7:0]  data;
  } acc_t;

  typedef struct {
    logic        pass;
    logic        fail;
    logic        to;
    logic [7:0]  ec;
    logic [31:0] fea;
    logic [7:0]  lrd;
  } res_t;

  acc_t exp_acc[$];
  res_t exp_res[$];
  int   res_seen = 0;
  logic [7:0] ref_last = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- controller model ----------------
  logic        stuck_en = 1'b0;
  logic        hold_mode = 1'b0;
  int          lat_cfg = 3;
  logic [7:0]  mem [logic [31:0]];
  int          m_lat = 0;
  int          m_wr = 0;
  logic        m_stall = 1'b0;
  logic [31:0] m_addr = '0;
  logic        m_we = 1'b0;

  function automatic logic [7:0] rd_word(input logic [31:0] a);
    logic [7:0] v;
    v = mem.exists(a) ? mem[a] : 8'h00;
    if (stuck_en && a == 32'h104) v[0] = 1'b1;
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_done  <= 1'b1;
      mem_rdata <= 8'h00;
      m_lat   = 0;
      m_stall = 1'b0;
      m_wr    = 0;
    end else begin
      if (start && !busy) m_wr = 0;
      if (m_stall) begin
        if (!hold_mode) begin
          mem_done <= 1'b1;
          m_stall = 1'b0;
        end
      end else if (m_lat > 0) begin
        m_lat--;
        if (m_lat == 0) begin
          if (hold_mode && m_we && m_wr >= 3) m_stall = 1'b1;
          else begin
            mem_done <= 1'b1;
            if (!m_we) mem_rdata <= rd_word(m_addr);
          end
        end
      end else if (mem_go) begin
        mem_done <= 1'b0;
        m_addr = mem_addr;
        m_we   = mem_we;
        m_lat  = lat_cfg;
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          m_wr++;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] pat(input logic [7:0] s, input int i, input logic inv);
    logic [7:0] t;
    t = s + 8'(i);
    return inv ? ~t : t;
  endfunction

  task automatic queue_expect(input logic [31:0] b, input logic [7:0] s, input logic inv,
                              input bit stall);
    acc_t a;
    res_t r;
    int nerr = 0;
    logic [31:0] fea = '0;
    logic [7:0] lrd = ref_last;
    logic [7:0] rd;
    for (int i = 0; i < NW; i++) begin
      a.addr = b + 32'(i); a.we = 1'b1; a.data = pat(s, i, inv);
      exp_acc.push_back(a);
      if (stall && i == 2) break;
    end
    if (!stall) begin
      for (int i = 0; i < NW; i++) begin
        a.addr = b + 32'(i); a.we = 1'b0; a.data = pat(s, i, inv);
        exp_acc.push_back(a);
        rd = a.data;
        if (stuck_en && a.addr == 32'h104) rd[0] = 1'b1;
        if (rd != a.data) begin
          if (nerr == 0) fea = a.addr;
          nerr++;
        end
        lrd = rd;
      end
      r.pass = (nerr == 0); r.fail = (nerr != 0); r.to = 1'b0;
      r.ec = (nerr > 255) ? 8'hFF : 8'(nerr); r.fea = fea; r.lrd = lrd;
    end else begin
      r.pass = 1'b0; r.fail = 1'b1; r.to = 1'b1; r.ec = 8'h00; r.fea = '0; r.lrd = ref_last;
    end
    ref_last = r.lrd;
    exp_res.push_back(r);
  endtask

  // ---------------- monitors ----------------
  acc_t mon_a;
  always @(negedge clk) begin
    if (!rst && mem_go) begin
      check("go_while_done_low", {31'd0, mem_done}, 32'd1);
      check("busy_during_go", {31'd0, busy}, 32'd1);
      if (exp_acc.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_go: got addr %h expected no access", mem_addr);
      end else begin
        mon_a = exp_acc.pop_front();
        check("acc_addr", mem_addr, mon_a.addr);
        check("acc_we", {31'd0, mem_we}, {31'd0, mon_a.we});
        if (mon_a.we) check("acc_wdata", {24'd0, mem_wdata}, {24'd0, mon_a.data});
      end
    end
  end

  initial begin : res_mon
    logic pb;
    res_t r;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) pb = 1'b0;
      else begin
        if (pb && !busy) begin
          @(negedge clk);
          if (!rst) begin
            if (exp_res.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_result: got pass=%0d fail=%0d expected none", pass, fail);
            end else begin
              r = exp_res.pop_front();
              check("res_pass", {31'd0, pass}, {31'd0, r.pass});
              check("res_fail", {31'd0, fail}, {31'd0, r.fail});
              check("res_timeout", {31'd0, timeout}, {31'd0, r.to});
              check("res_err_count", {24'd0, err_count}, {24'd0, r.ec});
              check("res_first_err_addr", first_err_addr, r.fea);
              check("res_last_rdata", {24'd0, last_rdata}, {24'd0, r.lrd});
              check("res_busy", {31'd0, busy}, 32'd0);
            end
            res_seen++;
          end
        end
        pb = busy;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_start(input logic [31:0] b, input logic [7:0] s, input logic inv);
    @(negedge clk);
    base_addr = b; seed = s; invert = inv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base_addr = $urandom; seed = 8'($urandom); invert = 1'($urandom);
  endtask

  task automatic wait_result(output int cyc);
    int n;
    n = res_seen;
    cyc = 0;
    while (cyc < 5000 && res_seen == n) begin
      @(negedge clk);
      cyc++;
    end
    if (res_seen == n) begin
      checks++; errors++;
      $display("FAIL result_wait: got no result after %0d cycles expected completion", cyc);
    end
    check("acc_drained", 32'(exp_acc.size()), 32'd0);
  endtask

  task automatic run(input logic [31:0] b, input logic [7:0] s, input logic inv);
    int cyc;
    queue_expect(b, s, inv, 1'b0);
    do_start(b, s, inv);
    wait_result(cyc);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_mem_go"}, {31'd0, mem_go}, 32'd0);
    check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
    check({tag, "_flags"}, {28'd0, busy, pass, fail, timeout}, 32'd0);
    check({tag, "_err_count"}, {24'd0, err_count}, 32'd0);
    check({tag, "_first_err_addr"}, first_err_addr, 32'd0);
    check({tag, "_last_rdata"}, {24'd0, last_rdata}, 32'd0);
  endtask

  initial begin
    int cyc;
    int gos;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;

    // basic pass, with ignored start pulses while busy
    queue_expect(32'h100, 8'h00, 1'b0, 1'b0);
    do_start(32'h100, 8'h00, 1'b0);
    repeat (10) @(negedge clk);
    start = 1'b1; base_addr = 32'h5555; seed = 8'hAA; invert = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_result(cyc);

    // stuck bit at 0x104
    stuck_en = 1'b1;
    run(32'h100, 8'h00, 1'b0);
    stuck_en = 1'b0;

    run(32'h100, 8'hF0, 1'b1);
    run(32'hFFFF_FFF8, 8'h00, 1'b0);

    // controller stalls after the 3rd write
    hold_mode = 1'b1;
    queue_expect(32'h200, 8'h11, 1'b0, 1'b1);
    do_start(32'h200, 8'h11, 1'b0);
    wait_result(cyc);
    checks++;
    if (cyc < TO || cyc > TO + 40) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles expected %0d..%0d", cyc, TO, TO + 40);
    end
    gos = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_go) gos++;
    end
    check("no_go_after_timeout", 32'(gos), 32'd0);
    hold_mode = 1'b0;
    repeat (3) @(negedge clk);
    run(32'h300, 8'h42, 1'b0);

    // randomized tests
    for (int t = 0; t < 8; t++) begin
      logic [31:0] b;
      b = ($urandom_range(0, 1) == 0) ? 32'(32'h0F8 + $urandom_range(0, 16)) : $urandom;
      stuck_en = 1'($urandom);
      lat_cfg = $urandom_range(1, 5);
      run(b, 8'($urandom), 1'($urandom));
    end
    stuck_en = 1'b0;
    lat_cfg = 3;

    // reset during the read phase
    queue_expect(32'h400, 8'h33, 1'b0, 1'b0);
    do_start(32'h400, 8'h33, 1'b0);
    cyc = 0;
    while (cyc < 2000 && exp_acc.size() > 8) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_read_phase", {31'd0, (exp_acc.size() <= 8)}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_zero_outputs("midreset");
    exp_acc.delete();
    exp_res.delete();
    ref_last = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run(32'h500, 8'h07, 1'b1);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
